// File: rtl/spi_write_arbiter.sv
// spi_write_arbiter: round-robin arbiter feeding two requesters' words into one SPI core.
// Ports:
//   clk_i, rst_n                - clock, asynchronous active-low reset
//   reqN_valid_i/data_i         - requester N has a word pending / the word
//   reqN_ready_o                - word accepted when valid & ready (IDLE only)
//   reqN_done_o                 - one-cycle pulse when requester N's transfer completes
//   spi_sdo_data_o/valid_o      - word and one-cycle load strobe to the SPI core
//   spi_sdo_ready_i             - SPI core busy-shifting flag
//   busy_o, owner_o             - FSM not idle / index of current or last grant
//   err_timeout_o               - one-cycle pulse when a transfer times out
module spi_write_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  req0_valid_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  output logic                  req0_done_o,
  input  logic                  req1_valid_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  output logic                  req1_done_o,
  output logic [DATA_WIDTH-1:0] spi_sdo_data_o,
  output logic                  spi_sdo_valid_o,
  input  logic                  spi_sdo_ready_i,
  output logic                  busy_o,
  output logic                  owner_o,
  output logic                  err_timeout_o
);
  // One counter serves both the wait timeout and the inter-transfer gap.
  localparam int CMAX = TIMEOUT_CYCLES > 15 ? TIMEOUT_CYCLES : 15;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP} state_e;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  owner_q, owner_d, last_q, last_d, err_q, err_d;
  logic [1:0]            done_q, done_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  grant1, waiting, complete, expired;
  always_comb begin
    grant1       = req1_valid_i & (~req0_valid_i | ~last_q);
    req1_ready_o = (state_q == IDLE) & grant1;
    req0_ready_o = (state_q == IDLE) & req0_valid_i & ~grant1;
    waiting      = (state_q == WAIT_START) || (state_q == WAIT_DONE);
    complete     = (state_q == WAIT_DONE) && !spi_sdo_ready_i;
    // Completion in the final allowed cycle beats the timeout.
    expired      = waiting && (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !complete;
    state_d      = state_q;
    data_d       = data_q;
    owner_d      = owner_q;
    last_d       = last_q;
    done_d       = '0;
    err_d        = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: if (req0_ready_o || req1_ready_o) begin
        state_d = ISSUE;
        data_d  = req1_ready_o ? req1_data_i : req0_data_i;
        owner_d = req1_ready_o;
        last_d  = req1_ready_o;
      end
      ISSUE: begin
        state_d = WAIT_START;
        cnt_d   = '0;
      end
      WAIT_START: state_d = spi_sdo_ready_i ? WAIT_DONE : WAIT_START;
      WAIT_DONE: if (complete) begin
        state_d = GAP;
        done_d  = owner_q ? 2'b10 : 2'b01;
      end
      GAP: begin
        state_d = (cnt_q == CW'(GAP_CYCLES - 1)) ? IDLE : GAP;
        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (waiting) cnt_d = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    if (expired) begin
      state_d = GAP;
      err_d   = 1'b1;
    end
    if (state_d == GAP && state_q != GAP) cnt_d = '0;
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign spi_sdo_data_o  = data_q;
  assign spi_sdo_valid_o = state_q == ISSUE;
  assign busy_o          = state_q != IDLE;
  assign owner_o         = owner_q;
  assign req0_done_o     = done_q[0];
  assign req1_done_o     = done_q[1];
  assign err_timeout_o   = err_q;
endmodule

// File: tb/tb_spi_write_arbiter.sv
// tb_spi_write_arbiter: directed self-checking bench for spi_write_arbiter.
module tb_spi_write_arbiter;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, rdy_a, rdy_b = 1'b0;
  logic [31:0] d0 = '0, d1 = '0;
  logic a_r0, a_r1, a_d0, a_d1, a_val, a_busy, a_own, a_err;
  logic b_r0, b_r1, b_d0, b_d1, b_val, b_busy, b_own, b_err;
  logic [31:0] a_data, b_data;
  int checks = 0, errors = 0, cyc = 0, a_hold = 3;
  int a_stb_cyc[$], a_done_cyc[$];
  logic [31:0] a_stb_data[$];
  logic a_stb_own[$];
  int a_d0_n = 0, a_d1_n = 0, a_err_n = 0, b_done_n = 0, b_err_n = 0, b_stb_c = 0, b_err_c = 0;

  spi_write_arbiter dut_a (
    .clk_i(clk_i), .rst_n(rst_n),
    .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(a_r0), .req0_done_o(a_d0),
    .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(a_r1), .req1_done_o(a_d1),
    .spi_sdo_data_o(a_data), .spi_sdo_valid_o(a_val), .spi_sdo_ready_i(rdy_a),
    .busy_o(a_busy), .owner_o(a_own), .err_timeout_o(a_err));

  spi_write_arbiter #(.TIMEOUT_CYCLES(16)) dut_b (
    .clk_i(clk_i), .rst_n(rst_n),
    .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(b_r0), .req0_done_o(b_d0),
    .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(b_r1), .req1_done_o(b_d1),
    .spi_sdo_data_o(b_data), .spi_sdo_valid_o(b_val), .spi_sdo_ready_i(rdy_b),
    .busy_o(b_busy), .owner_o(b_own), .err_timeout_o(b_err));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (a_val === 1'b1) begin
      a_stb_cyc.push_back(cyc);
      a_stb_data.push_back(a_data);
      a_stb_own.push_back(a_own);
    end
    if (a_d0 === 1'b1 || a_d1 === 1'b1) a_done_cyc.push_back(cyc);
    if (a_d0 === 1'b1) a_d0_n++;
    if (a_d1 === 1'b1) a_d1_n++;
    if (a_err === 1'b1) a_err_n++;
    if (b_val === 1'b1) b_stb_c = cyc;
    if (b_d0 === 1'b1 || b_d1 === 1'b1) b_done_n++;
    if (b_err === 1'b1) begin
      b_err_n++;
      b_err_c = cyc;
    end
  end

  // SPI core model for dut_a: busy rises 2 cycles after the strobe and stays a_hold cycles.
  initial begin
    rdy_a = 1'b0;
    forever begin
      @(negedge clk_i);
      if (a_val === 1'b1) begin
        @(negedge clk_i);
        @(negedge clk_i);
        rdy_a = 1'b1;
        repeat (a_hold) @(negedge clk_i);
        rdy_a = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; rdy_b = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({a_busy, a_val, a_own, a_d0, a_d1, a_err, a_r0, a_r1} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b want 00000000", {a_busy, a_val, a_own, a_d0, a_d1, a_err, a_r0, a_r1});
    end
    checks++;
    if (a_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data_a: got %h want 00000000", a_data);
    end
    checks++;
    if ({b_busy, b_val, b_own, b_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl_b: got %b want 0000", {b_busy, b_val, b_own, b_err});
    end
    do_reset();
  endtask

  task automatic test_single();
    int s, n0, n1, e;
    do_reset();
    a_hold = 32;
    s = a_stb_cyc.size(); n0 = a_d0_n; n1 = a_d1_n; e = a_err_n;
    v0 = 1'b1; d0 = 32'hA5A5_0001;
    #1;
    checks++;
    if ({a_r0, a_r1} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: got %b want 10", {a_r0, a_r1});
    end
    @(negedge clk_i);
    checks++;
    if ({a_val, a_busy, a_r0} !== 3'b110) begin
      errors++;
      $display("FAIL single_issue: got %b want 110", {a_val, a_busy, a_r0});
    end
    checks++;
    if (a_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_data: got %h want a5a50001", a_data);
    end
    v0 = 1'b0;
    @(negedge clk_i);
    checks++;
    if (a_val !== 1'b0) begin
      errors++;
      $display("FAIL single_strobe_len: got %b want 0", a_val);
    end
    repeat (45) @(negedge clk_i);
    checks++;
    if (a_d0_n - n0 != 1 || a_d1_n - n1 != 0 || a_err_n - e != 0) begin
      errors++;
      $display("FAIL single_pulses: got d0=%0d d1=%0d err=%0d want 1 0 0", a_d0_n - n0, a_d1_n - n1, a_err_n - e);
    end
    checks++;
    if (a_stb_cyc.size() - s != 1 || a_busy !== 1'b0 || a_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_end: got strobes=%0d busy=%b data=%h want 1 0 a5a50001", a_stb_cyc.size() - s, a_busy, a_data);
    end
  endtask

  task automatic test_tie();
    int s;
    logic [31:0] exp_d;
    do_reset();
    a_hold = 2;
    s = a_stb_cyc.size();
    v0 = 1'b1; d0 = 32'h11; v1 = 1'b1; d1 = 32'h22;
    for (int i = 0; i < 300 && a_stb_cyc.size() < s + 4; i++) @(negedge clk_i);
    v0 = 1'b0; v1 = 1'b0;
    checks++;
    if (a_stb_cyc.size() < s + 4) begin
      errors++;
      $display("FAIL tie_count: got %0d want 4", a_stb_cyc.size() - s);
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_d = (k % 2 == 1) ? 32'h22 : 32'h11;
        checks++;
        if (a_stb_data[s+k] !== exp_d || a_stb_own[s+k] !== (k % 2 == 1)) begin
          errors++;
          $display("FAIL tie_order[%0d]: got data=%h owner=%b want %h %b", k, a_stb_data[s+k], a_stb_own[s+k], exp_d, k % 2 == 1);
        end
      end
    end
    repeat (20) @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    int s, ds, n0, n1;
    logic [31:0] w[3];
    w[0] = 32'hCAFE_0000; w[1] = 32'hCAFE_0001; w[2] = 32'hCAFE_0002;
    do_reset();
    a_hold = 3;
    s = a_stb_cyc.size(); ds = a_done_cyc.size(); n0 = a_d0_n; n1 = a_d1_n;
    v1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d1 = w[k];
      #1;
      for (int i = 0; i < 100 && a_r1 !== 1'b1; i++) @(negedge clk_i);
      checks++;
      if (a_r1 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", k, a_r1);
      end
      @(negedge clk_i);
    end
    v1 = 1'b0;
    repeat (20) @(negedge clk_i);
    checks++;
    if (a_stb_cyc.size() - s != 3 || a_d1_n - n1 != 3 || a_d0_n - n0 != 0) begin
      errors++;
      $display("FAIL b2b_counts: got strobes=%0d d1=%0d d0=%0d want 3 3 0", a_stb_cyc.size() - s, a_d1_n - n1, a_d0_n - n0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (a_stb_data[s+k] !== w[k] || a_stb_own[s+k] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %h owner=%b want %h 1", k, a_stb_data[s+k], a_stb_own[s+k], w[k]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_stb_cyc[s+k+1] - a_done_cyc[ds+k] != 3) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d want 3", k, a_stb_cyc[s+k+1] - a_done_cyc[ds+k]);
        end
      end
    end
  endtask

  task automatic test_timeout(input bit stuck);
    int e, dn;
    do_reset();
    e = b_err_n; dn = b_done_n;
    v0 = 1'b1; d0 = 32'h0000_BEEF;
    @(negedge clk_i);
    v0 = 1'b0;
    @(negedge clk_i);
    if (stuck) rdy_b = 1'b1;
    repeat (30) @(negedge clk_i);
    rdy_b = 1'b0;
    checks++;
    if (b_err_n - e != 1 || b_done_n - dn != 0) begin
      errors++;
      $display("FAIL timeout_pulses stuck=%0d: got err=%0d done=%0d want 1 0", stuck, b_err_n - e, b_done_n - dn);
    end
    checks++;
    if (b_err_c - b_stb_c != 17) begin
      errors++;
      $display("FAIL timeout_latency stuck=%0d: got %0d want 17", stuck, b_err_c - b_stb_c);
    end
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle stuck=%0d: got busy=%b want 0", stuck, b_busy);
    end
  endtask

  task automatic test_complete_wins();
    int e, dn;
    do_reset();
    e = b_err_n; dn = b_done_n;
    v0 = 1'b1; d0 = 32'h0000_0077;
    @(negedge clk_i);
    v0 = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rdy_b = 1'b1;
    repeat (14) @(negedge clk_i);
    rdy_b = 1'b0;
    repeat (10) @(negedge clk_i);
    checks++;
    if (b_done_n - dn != 1 || b_err_n - e != 0) begin
      errors++;
      $display("FAIL complete_wins: got done=%0d err=%0d want 1 0", b_done_n - dn, b_err_n - e);
    end
  endtask

  task automatic test_reset_mid();
    int n0, n1, e;
    do_reset();
    a_hold = 10;
    v1 = 1'b1; d1 = 32'hDEAD_BEEF;
    @(negedge clk_i);
    v1 = 1'b0;
    repeat (5) @(negedge clk_i);
    checks++;
    if ({a_busy, a_own} !== 2'b11) begin
      errors++;
      $display("FAIL mid_busy: got %b want 11", {a_busy, a_own});
    end
    n0 = a_d0_n; n1 = a_d1_n; e = a_err_n;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_val, a_own, a_d0, a_d1, a_err} !== 6'b0 || a_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_async: got ctrl=%b data=%h want 000000 00000000", {a_busy, a_val, a_own, a_d0, a_d1, a_err}, a_data);
    end
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && rdy_a !== 1'b0; i++) @(negedge clk_i);
    repeat (2) @(negedge clk_i);
    checks++;
    if (a_d0_n - n0 != 0 || a_d1_n - n1 != 0 || a_err_n - e != 0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_quiet: got d0=%0d d1=%0d err=%0d busy=%b want 0 0 0 0", a_d0_n - n0, a_d1_n - n1, a_err_n - e, a_busy);
    end
    v0 = 1'b1; d0 = 32'h0000_1234; v1 = 1'b1; d1 = 32'h0000_5678;
    #1;
    checks++;
    if ({a_r0, a_r1} !== 2'b10) begin
      errors++;
      $display("FAIL mid_tie: got %b want 10", {a_r0, a_r1});
    end
    @(negedge clk_i);
    v0 = 1'b0; v1 = 1'b0;
    checks++;
    if (a_data !== 32'h0000_1234 || a_val !== 1'b1) begin
      errors++;
      $display("FAIL mid_serve: got data=%h valid=%b want 00001234 1", a_data, a_val);
    end
    repeat (25) @(negedge clk_i);
    checks++;
    if (a_d0_n - n0 != 1 || a_d1_n - n1 != 0) begin
      errors++;
      $display("FAIL mid_done: got d0=%0d d1=%0d want 1 0", a_d0_n - n0, a_d1_n - n1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_complete_wins();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_write_arbiter.md
SPI_WRITE_ARBITER -- requirements
Module: spi_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the SPI word width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles allowed in WAIT_START plus WAIT_DONE.
REQ-003 SHALL have parameter GAP_CYCLES, default 2 (legal range 1..15), meaning the number of idle cycles between transfers.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports req0_valid_i / req1_valid_i, input, 1 bit each: requester has a word pending.
REQ-007 SHALL have ports req0_data_i / req1_data_i, input, DATA_WIDTH each: requester word.
REQ-008 SHALL have ports req0_ready_o / req1_ready_o, output, 1 bit each: word accepted when valid and ready are both high in the same cycle.
REQ-009 SHALL have ports req0_done_o / req1_done_o, output, 1 bit each: one-cycle pulse when that requester's transfer completes.
REQ-010 SHALL have port spi_sdo_data_o, output, DATA_WIDTH: word driven to the SPI core.
REQ-011 SHALL have port spi_sdo_valid_o, output, 1 bit: one-cycle load strobe to the SPI core.
REQ-012 SHALL have port spi_sdo_ready_i, input, 1 bit: SPI core busy-shifting flag (high during shift).
REQ-013 SHALL have port busy_o, output, 1 bit: FSM not in IDLE.
REQ-014 SHALL have port owner_o, output, 1 bit: index of the current or most recent grant.
REQ-015 SHALL have port err_timeout_o, output, 1 bit: one-cycle pulse on timeout.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP.
REQ-017 SHALL make reqN_ready_o combinational: high only in IDLE for the selected requester; never both high.
REQ-018 Selection in IDLE SHALL work as follows: if only one valid, grant it; if both valid, grant the requester not equal to last_grant (round-robin).
REQ-019 On acceptance, the block SHALL latch reqN_data_i into spi_sdo_data_o, set owner_o and last_grant to N, and go to ISSUE next cycle.
REQ-020 spi_sdo_data_o SHALL hold its value until the next acceptance and SHALL NOT be cleared on completion.
REQ-021 spi_sdo_valid_o SHALL be high for exactly the one ISSUE cycle, which is the cycle after acceptance; the FSM then enters WAIT_START.
REQ-022 WAIT_START SHALL go to WAIT_DONE on the first cycle spi_sdo_ready_i=1.
REQ-023 WAIT_DONE SHALL go to GAP on the first cycle spi_sdo_ready_i=0, and reqN_done_o for the owner SHALL pulse for one cycle, registered, in the first GAP cycle.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; no requester is accepted during GAP.
REQ-025 The timeout counter SHALL clear on entry to WAIT_START, increment every cycle in WAIT_START/WAIT_DONE, and saturate.
REQ-026 If TIMEOUT_CYCLES cycles elapse in WAIT_START+WAIT_DONE without completion, the block SHALL pulse err_timeout_o for one cycle, enter GAP, and assert no done pulse.
REQ-027 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-028 Requester valid changes outside IDLE SHALL be ignored; a deasserted valid before acceptance SHALL leave no effect.
REQ-029 busy_o SHALL equal (state != IDLE).

Reset
REQ-030 On rst_n=0, the block SHALL asynchronously force IDLE and set spi_sdo_valid_o=0, spi_sdo_data_o=0, done pulses=0, err_timeout_o=0, owner_o=0, last_grant=1 (requester 0 wins the first tie), and counters=0.
REQ-031 Reset asserted mid-transfer SHALL abort with no done or err pulse; after release, the block SHALL be in IDLE with no pending state.

Verification
REQ-032 Single write: req0 valid with 0xA5A5_0001; SPI model raises ready 2 cycles after strobe, holds it 32 cycles -> req0_ready_o high at T, spi_sdo_valid_o high at T+1 only, data=0xA5A5_0001, one req0_done_o pulse, no req1_done_o, no err.
REQ-033 Tie after reset: req0=0x11, req1=0x22 held valid -> served in order 0x11, 0x22, 0x11, 0x22; owner_o alternates.
REQ-034 Back-to-back: req1 only, 3 words -> three strobes; each strobe occurs GAP_CYCLES+1 cycles after the previous done pulse, with GAP_CYCLES=2.
REQ-035 Timeout: TIMEOUT_CYCLES=16, spi_sdo_ready_i held 0 -> err_timeout_o pulses 16 cycles after entering WAIT_START, no done pulse, IDLE after GAP.
REQ-036 Stuck busy: ready rises and never falls, TIMEOUT_CYCLES=16 -> err pulse, no done pulse.
REQ-037 Reset mid-WAIT_DONE: rst_n low 3 cycles -> all outputs at reset values immediately, no pulses; the next request is served normally with req0 winning the tie.
